// File: rtl/rx_pkt_gen_tdpram_1clk_if.sv
// Signal bundle for the two-port RAM: per-port request/return, memory clear control and collision status.
interface rx_pkt_gen_tdpram_1clk_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic                    en_a, we_a, dvalid_a;
  logic [DATA_WIDTH/8-1:0] be_a;
  logic [ADDR_WIDTH-1:0]   addr_a;
  logic [DATA_WIDTH-1:0]   din_a, dout_a;

  logic                    en_b, we_b, dvalid_b;
  logic [DATA_WIDTH/8-1:0] be_b;
  logic [ADDR_WIDTH-1:0]   addr_b;
  logic [DATA_WIDTH-1:0]   din_b, dout_b;

  logic                    init_start, init_busy;
  logic                    coll_ww, coll_rw;
  logic [15:0]             coll_cnt;

  modport master (
    output en_a, we_a, be_a, addr_a, din_a,
    output en_b, we_b, be_b, addr_b, din_b,
    output init_start,
    input  dout_a, dvalid_a, dout_b, dvalid_b,
    input  init_busy, coll_ww, coll_rw, coll_cnt
  );

  modport slave (
    input  en_a, we_a, be_a, addr_a, din_a,
    input  en_b, we_b, be_b, addr_b, din_b,
    input  init_start,
    output dout_a, dvalid_a, dout_b, dvalid_b,
    output init_busy, coll_ww, coll_rw, coll_cnt
  );
endinterface

// File: rtl/rx_pkt_gen_tdpram_1clk.sv
// True dual-port RAM on one clock with byte enables, fixed-latency read returns on both ports,
// a whole-memory clear sequencer and same-address collision reporting.
module rx_pkt_gen_tdpram_1clk #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LATENCY = 2,
  parameter int WR_MODE    = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  rx_pkt_gen_tdpram_1clk_if.slave bus
);
  localparam int BW    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [BW-1:0]         be_t;
  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic word_t merge(input word_t old, input word_t din, input be_t be);
    word_t r;
    r = old;
    for (int i = 0; i < BW; i++) begin
      if (be[i]) r[8*i +: 8] = din[8*i +: 8];
    end
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
  word_t                 mem_q [DEPTH];

  logic  busy, acc_a, acc_b, wr_a, wr_b, same, ww, rw;
  word_t old_a, old_b, new_a, new_b, ret_a, ret_b;

  logic [RD_LATENCY-1:0] va_q, vb_q;
  word_t                 da_q [RD_LATENCY];
  word_t                 db_q [RD_LATENCY];
  logic                  coll_ww_q, coll_rw_q;
  logic [15:0]           coll_cnt_q;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    case (state_q)
      IDLE: begin
        if (bus.init_start) begin
          state_d = CLEAR;
          clr_d   = '0;
        end
      end
      CLEAR: begin
        clr_d = clr_q + ADDR_WIDTH'(1);
        if (&clr_q) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  assign busy  = (state_q == CLEAR);
  assign acc_a = bus.en_a & ~busy & rst_n;
  assign acc_b = bus.en_b & ~busy & rst_n;
  assign wr_a  = acc_a & bus.we_a;
  assign wr_b  = acc_b & bus.we_b;
  assign same  = (bus.addr_a == bus.addr_b);

  // B's bytes go in first so A's enabled bytes overwrite them on a shared address.
  assign old_a = mem_q[bus.addr_a];
  assign old_b = mem_q[bus.addr_b];
  assign new_a = merge(merge(old_a, bus.din_b, (wr_b && same) ? bus.be_b : be_t'(0)),
                       bus.din_a, wr_a ? bus.be_a : be_t'(0));
  assign new_b = merge(merge(old_b, bus.din_b, wr_b ? bus.be_b : be_t'(0)),
                       bus.din_a, (wr_a && same) ? bus.be_a : be_t'(0));
  assign ret_a = (WR_MODE != 0) ? new_a : old_a;
  assign ret_b = (WR_MODE != 0) ? new_b : old_b;

  assign ww = wr_a & wr_b & same;
  assign rw = same & ((wr_a & acc_b & ~bus.we_b) | (wr_b & acc_a & ~bus.we_a));

  // Memory contents survive reset; the clear sequencer and port writes never overlap.
  always_ff @(posedge clk) begin
    if (busy) mem_q[clr_q] <= '0;
    if (wr_a) mem_q[bus.addr_a] <= new_a;
    if (wr_b) mem_q[bus.addr_b] <= new_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va_q       <= '0;
      vb_q       <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        da_q[i] <= '0;
        db_q[i] <= '0;
      end
      coll_ww_q  <= 1'b0;
      coll_rw_q  <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      va_q[0] <= acc_a;
      vb_q[0] <= acc_b;
      if (acc_a) da_q[0] <= ret_a;
      if (acc_b) db_q[0] <= ret_b;
      // Data only advances with its valid so the last stage holds its value between returns.
      for (int i = 1; i < RD_LATENCY; i++) begin
        va_q[i] <= va_q[i-1];
        vb_q[i] <= vb_q[i-1];
        if (va_q[i-1]) da_q[i] <= da_q[i-1];
        if (vb_q[i-1]) db_q[i] <= db_q[i-1];
      end
      coll_ww_q <= ww;
      coll_rw_q <= rw;
      if ((ww | rw) && !(&coll_cnt_q)) coll_cnt_q <= coll_cnt_q + 16'd1;
    end
  end

  assign bus.dout_a    = da_q[RD_LATENCY-1];
  assign bus.dvalid_a  = va_q[RD_LATENCY-1];
  assign bus.dout_b    = db_q[RD_LATENCY-1];
  assign bus.dvalid_b  = vb_q[RD_LATENCY-1];
  assign bus.init_busy = busy;
  assign bus.coll_ww   = coll_ww_q;
  assign bus.coll_rw   = coll_rw_q;
  assign bus.coll_cnt  = coll_cnt_q;
endmodule

// File: tb/tb_rx_pkt_gen_tdpram_1clk.sv
// Drives one latency-1/read-first and one latency-2/write-first instance with identical stimulus
// and checks both against a word-level memory model.
module tb_rx_pkt_gen_tdpram_1clk;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          en_a, we_a, en_b, we_b, init_start;
  logic [3:0]    be_a, be_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b;

  rx_pkt_gen_tdpram_1clk_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  rx_pkt_gen_tdpram_1clk_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  assign {bus1.en_a, bus1.we_a, bus1.be_a, bus1.addr_a, bus1.din_a} = {en_a, we_a, be_a, addr_a, din_a};
  assign {bus1.en_b, bus1.we_b, bus1.be_b, bus1.addr_b, bus1.din_b} = {en_b, we_b, be_b, addr_b, din_b};
  assign {bus2.en_a, bus2.we_a, bus2.be_a, bus2.addr_a, bus2.din_a} = {en_a, we_a, be_a, addr_a, din_a};
  assign {bus2.en_b, bus2.we_b, bus2.be_b, bus2.addr_b, bus2.din_b} = {en_b, we_b, be_b, addr_b, din_b};
  assign bus1.init_start = init_start;
  assign bus2.init_start = init_start;

  rx_pkt_gen_tdpram_1clk #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .WR_MODE(0)) u_l1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  rx_pkt_gen_tdpram_1clk #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .WR_MODE(1)) u_l2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [169:0] obs_all, exp_all;
  assign obs_all = {bus1.dvalid_a, bus1.dout_a, bus1.dvalid_b, bus1.dout_b,
                    bus2.dvalid_a, bus2.dout_a, bus2.dvalid_b, bus2.dout_b,
                    bus1.coll_ww, bus1.coll_rw, bus1.coll_cnt, bus1.init_busy,
                    bus2.coll_ww, bus2.coll_rw, bus2.coll_cnt, bus2.init_busy};

  // Reference model state
  logic [DW-1:0] m_mem  [DEPTH];
  logic [DW-1:0] fill_v [DEPTH];
  bit            m_busy;
  int            m_clr;
  logic [15:0]   m_cnt;
  logic          p2va, p2vb;
  logic [DW-1:0] p2da, p2db, h1a, h1b, h2a, h2b;

  int errors = 0;
  int checks = 0;

  task automatic model_reset();
    p2va = 0; p2vb = 0; p2da = 0; p2db = 0;
    h1a = 0; h1b = 0; h2a = 0; h2b = 0;
    m_cnt = 0; m_busy = 0; m_clr = 0;
    exp_all = '0;
  endtask

  task automatic set_idle();
    en_a = 0; we_a = 0; be_a = 0; addr_a = 0; din_a = 0;
    en_b = 0; we_b = 0; be_b = 0; addr_b = 0; din_b = 0;
    init_start = 0;
  endtask

  task automatic drv_a(input logic e, input logic w, input logic [3:0] be, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    en_a = e; we_a = w; be_a = be; addr_a = ad; din_a = d;
  endtask

  task automatic drv_b(input logic e, input logic w, input logic [3:0] be, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    en_b = e; we_b = w; be_b = be; addr_b = ad; din_b = d;
  endtask

  task automatic drive_random(input int max_addr);
    drv_a(($urandom % 4) != 0, $urandom % 2, 4'($urandom), AW'($urandom_range(0, max_addr)), $urandom);
    drv_b(($urandom % 4) != 0, $urandom % 2, 4'($urandom), AW'($urandom_range(0, max_addr)), $urandom);
  endtask

  // Applies the current inputs to the model, advances one clock and leaves exp_all at what both DUTs should show.
  task automatic tick();
    logic aa, ab, ww, rw, sm;
    logic [DW-1:0] oa, ob, na, nb;
    aa = rst_n && en_a && !m_busy;
    ab = rst_n && en_b && !m_busy;
    oa = m_mem[addr_a];
    ob = m_mem[addr_b];
    if (ab && we_b) for (int k = 0; k < 4; k++) if (be_b[k]) m_mem[addr_b][8*k +: 8] = din_b[8*k +: 8];
    if (aa && we_a) for (int k = 0; k < 4; k++) if (be_a[k]) m_mem[addr_a][8*k +: 8] = din_a[8*k +: 8];
    na = m_mem[addr_a];
    nb = m_mem[addr_b];
    sm = (addr_a == addr_b);
    ww = aa && ab && we_a && we_b && sm;
    rw = aa && ab && sm && (we_a != we_b);
    if ((ww || rw) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (m_busy) begin
      m_mem[m_clr] = '0;
      m_clr++;
      if (m_clr == DEPTH) m_busy = 0;
    end else if (rst_n && init_start) begin
      m_busy = 1;
      m_clr  = 0;
    end
    @(posedge clk);
    if (aa) h1a = oa;
    if (ab) h1b = ob;
    if (p2va) h2a = p2da;
    if (p2vb) h2b = p2db;
    exp_all = {aa, h1a, ab, h1b, p2va, h2a, p2vb, h2b, ww, rw, m_cnt, m_busy, ww, rw, m_cnt, m_busy};
    p2va = aa; p2da = na;
    p2vb = ab; p2db = nb;
    #1;
  endtask

  task automatic fill_memory();
    for (int i = 0; i < DEPTH / 2; i++) begin
      drv_a(1, 1, 4'hF, AW'(2*i), $urandom);
      drv_b(1, 1, 4'hF, AW'(2*i+1), $urandom);
      fill_v[2*i]   = din_a;
      fill_v[2*i+1] = din_b;
      tick();
    end
    drv_a(1, 0, 4'h0, AW'(0), 0);
    drv_b(1, 0, 4'h0, AW'(1), 0);
    tick();
    set_idle();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1;
    set_idle();
    model_reset();
    #2 rst_n = 0;
    #1;
    checks++;
    if (obs_all !== '0) begin errors++; $display("FAIL reset_async got=%h exp=0", obs_all); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_all !== '0) begin errors++; $display("FAIL reset_hold got=%h exp=0", obs_all); end
    rst_n = 1;
  endtask

  task automatic test_init();
    int n;
    set_idle();
    init_start = 1;
    tick();
    init_start = 0;
    checks++;
    if (bus2.init_busy !== 1'b1 || bus1.init_busy !== 1'b1) begin
      errors++; $display("FAIL init_busy_rise got=%b%b exp=11", bus1.init_busy, bus2.init_busy);
    end
    n = 0;
    while (bus2.init_busy === 1'b1 && n < 3000) begin
      drive_random(DEPTH - 1);
      init_start = $urandom % 2;
      tick();
      n++;
      checks++;
      if (obs_all !== exp_all) begin errors++; $display("FAIL init_busy_cycle n=%0d got=%h exp=%h", n, obs_all, exp_all); end
    end
    set_idle();
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL init_busy_len got=%0d exp=%0d", n, DEPTH); end
    for (int i = 0; i < DEPTH / 2; i++) begin
      drv_a(1, 0, 4'h0, AW'(2*i), 0);
      drv_b(1, 0, 4'h0, AW'(2*i+1), 0);
      tick();
      checks++;
      if (obs_all !== exp_all) begin errors++; $display("FAIL init_readback i=%0d got=%h exp=%h", i, obs_all, exp_all); end
      checks++;
      if ({bus1.dvalid_a, bus1.dout_a, bus1.dvalid_b, bus1.dout_b} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
        errors++; $display("FAIL init_zero addr=%0d got=%h/%h exp=0/0", 2*i, bus1.dout_a, bus1.dout_b);
      end
    end
    set_idle();
    tick();
    tick();
  endtask

  task automatic test_basic_latency();
    set_idle();
    drv_a(1, 1, 4'hF, AW'(5), 32'hDEADBEEF);
    tick();
    set_idle();
    drv_b(1, 0, 4'h0, AW'(5), 0);
    tick();
    set_idle();
    checks++;
    if ({bus1.dvalid_b, bus1.dout_b, bus2.dvalid_b} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL lat1_read got=%b/%h lat2_vld=%b exp=1/deadbeef 0", bus1.dvalid_b, bus1.dout_b, bus2.dvalid_b);
    end
    tick();
    checks++;
    if ({bus2.dvalid_b, bus2.dout_b, bus1.dvalid_b} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL lat2_read got=%b/%h lat1_vld=%b exp=1/deadbeef 0", bus2.dvalid_b, bus2.dout_b, bus1.dvalid_b);
    end
    tick();
    checks++;
    if ({bus1.dvalid_b, bus2.dvalid_b} !== 2'b00 || bus2.dout_b !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_hold got=%b%b/%h exp=00/deadbeef", bus1.dvalid_b, bus2.dvalid_b, bus2.dout_b);
    end
  endtask

  task automatic test_byte_enable();
    set_idle();
    drv_a(1, 1, 4'hF, AW'(7), 32'h11223344);
    tick();
    drv_a(1, 1, 4'b0010, AW'(7), 32'hFFFFAAFF);
    tick();
    checks++;
    if ({bus1.dvalid_a, bus1.dout_a} !== {1'b1, 32'h11223344}) begin
      errors++; $display("FAIL be_write_old got=%b/%h exp=1/11223344", bus1.dvalid_a, bus1.dout_a);
    end
    drv_a(1, 1, 4'b0000, AW'(7), 32'h0);
    tick();
    checks++;
    if ({bus2.dvalid_a, bus2.dout_a, bus1.dvalid_a, bus1.dout_a} !== {1'b1, 32'h1122AA44, 1'b1, 32'h1122AA44}) begin
      errors++; $display("FAIL be_merge_ret got=%h/%h exp=1122aa44/1122aa44", bus2.dout_a, bus1.dout_a);
    end
    set_idle();
    drv_b(1, 0, 4'h0, AW'(7), 0);
    tick();
    set_idle();
    checks++;
    if ({bus1.dvalid_b, bus1.dout_b, bus2.dvalid_a, bus2.dout_a} !== {1'b1, 32'h1122AA44, 1'b1, 32'h1122AA44}) begin
      errors++; $display("FAIL be_readback got=%h noop_ret=%h exp=1122aa44", bus1.dout_b, bus2.dout_a);
    end
    tick();
    checks++;
    if ({bus2.dvalid_b, bus2.dout_b} !== {1'b1, 32'h1122AA44}) begin
      errors++; $display("FAIL be_readback_l2 got=%b/%h exp=1/1122aa44", bus2.dvalid_b, bus2.dout_b);
    end
  endtask

  task automatic test_ww_collision();
    set_idle();
    drv_a(1, 1, 4'hF, AW'(9), 32'hA);
    drv_b(1, 1, 4'hF, AW'(9), 32'hB);
    tick();
    set_idle();
    checks++;
    if ({bus1.coll_ww, bus1.coll_rw, bus1.coll_cnt, bus2.coll_ww, bus2.coll_rw, bus2.coll_cnt} !== {2'b10, 16'd1, 2'b10, 16'd1}) begin
      errors++; $display("FAIL ww_pulse got=%b%b/%0d exp=10/1", bus1.coll_ww, bus1.coll_rw, bus1.coll_cnt);
    end
    drv_a(1, 0, 4'h0, AW'(9), 0);
    tick();
    set_idle();
    checks++;
    if ({bus1.coll_ww, bus2.coll_ww, bus1.coll_cnt, bus2.coll_cnt} !== {2'b00, 16'd1, 16'd1}) begin
      errors++; $display("FAIL ww_one_cycle got=%b%b/%0d exp=00/1", bus1.coll_ww, bus2.coll_ww, bus1.coll_cnt);
    end
    checks++;
    if ({bus1.dvalid_a, bus1.dout_a} !== {1'b1, 32'hA}) begin
      errors++; $display("FAIL ww_a_wins got=%b/%h exp=1/0000000a", bus1.dvalid_a, bus1.dout_a);
    end
    drv_a(1, 1, 4'b0011, AW'(9), 32'h00005566);
    drv_b(1, 1, 4'b1110, AW'(9), 32'h778899AA);
    tick();
    set_idle();
    drv_b(1, 0, 4'h0, AW'(9), 0);
    tick();
    set_idle();
    checks++;
    if ({bus1.dvalid_b, bus1.dout_b, bus1.coll_cnt} !== {1'b1, 32'h77885566, 16'd2}) begin
      errors++; $display("FAIL ww_byte_merge got=%h cnt=%0d exp=77885566 cnt=2", bus1.dout_b, bus1.coll_cnt);
    end
    tick();
  endtask

  task automatic test_rw_collision();
    set_idle();
    drv_a(1, 1, 4'hF, AW'(3), 32'h1);
    tick();
    drv_a(1, 1, 4'hF, AW'(3), 32'h2);
    drv_b(1, 0, 4'h0, AW'(3), 0);
    tick();
    set_idle();
    checks++;
    if ({bus1.dvalid_b, bus1.dout_b, bus1.coll_rw, bus2.coll_rw, bus1.coll_ww, bus2.coll_cnt} !== {1'b1, 32'h1, 3'b110, 16'd3}) begin
      errors++; $display("FAIL rw_old_data got=%h rw=%b%b cnt=%0d exp=1 rw=11 cnt=3", bus1.dout_b, bus1.coll_rw, bus2.coll_rw, bus2.coll_cnt);
    end
    drv_b(1, 1, 4'hF, AW'(3), 32'h3);
    drv_a(1, 0, 4'h0, AW'(3), 0);
    tick();
    set_idle();
    checks++;
    if ({bus2.dvalid_b, bus2.dout_b, bus1.dvalid_a, bus1.dout_a} !== {1'b1, 32'h2, 1'b1, 32'h2}) begin
      errors++; $display("FAIL rw_new_data got=%h old_a=%h exp=2/2", bus2.dout_b, bus1.dout_a);
    end
    tick();
    checks++;
    if ({bus2.dvalid_a, bus2.dout_a, bus2.coll_rw, bus2.coll_cnt} !== {1'b1, 32'h3, 1'b0, 16'd4}) begin
      errors++; $display("FAIL rw_b_writes got=%h rw=%b cnt=%0d exp=3 rw=0 cnt=4", bus2.dout_a, bus2.coll_rw, bus2.coll_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive_random(7);
      tick();
      checks++;
      if (obs_all !== exp_all) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_all, exp_all); end
    end
    set_idle();
    tick();
    tick();
  endtask

  task automatic test_reset_inflight();
    set_idle();
    drv_a(1, 0, 4'h0, AW'(9), 0);
    drv_b(1, 0, 4'h0, AW'(3), 0);
    tick();
    set_idle();
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (obs_all !== '0) begin errors++; $display("FAIL reset_inflight_clear got=%h exp=0", obs_all); end
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus1.dvalid_a, bus1.dvalid_b, bus2.dvalid_a, bus2.dvalid_b} !== 4'b0000) begin
        errors++; $display("FAIL reset_drop cyc=%0d got=%b%b%b%b exp=0000", i, bus1.dvalid_a, bus1.dvalid_b, bus2.dvalid_a, bus2.dvalid_b);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    fill_memory();
    init_start = 1;
    tick();
    init_start = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (obs_all !== exp_all) begin errors++; $display("FAIL clear_run cyc=%0d got=%h exp=%h", i, obs_all, exp_all); end
    end
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (obs_all !== '0) begin errors++; $display("FAIL clear_abort got=%h exp=0", obs_all); end
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    checks++;
    if (bus1.init_busy !== 1'b0 || bus2.init_busy !== 1'b0) begin
      errors++; $display("FAIL clear_fsm_idle got=%b%b exp=00", bus1.init_busy, bus2.init_busy);
    end
    drv_a(1, 0, 4'h0, AW'(99), 0);
    drv_b(1, 0, 4'h0, AW'(100), 0);
    tick();
    checks++;
    if ({bus1.dvalid_a, bus1.dout_a, bus1.dvalid_b, bus1.dout_b} !== {1'b1, 32'h0, 1'b1, fill_v[100]}) begin
      errors++; $display("FAIL clear_edge got=%h/%h exp=0/%h", bus1.dout_a, bus1.dout_b, fill_v[100]);
    end
    for (int i = 0; i < DEPTH / 2; i++) begin
      drv_a(1, 0, 4'h0, AW'(2*i), 0);
      drv_b(1, 0, 4'h0, AW'(2*i+1), 0);
      tick();
      checks++;
      if (obs_all !== exp_all) begin errors++; $display("FAIL clear_partial i=%0d got=%h exp=%h", i, obs_all, exp_all); end
    end
    set_idle();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    fill_memory();
    test_init();
    test_basic_latency();
    test_byte_enable();
    test_ww_collision();
    test_rw_collision();
    test_random();
    test_reset_inflight();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rx_pkt_gen_tdpram_1clk.md
RX_PKT_GEN_TDPRAM_1CLK -- requirements
Module: rx_pkt_gen_tdpram_1clk

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter RD_LATENCY, default 2, read latency in cycles (legal values 1 or 2).
REQ-004 SHALL have parameter WR_MODE, default 1, read-during-write mode (0 = read-first/old data, 1 = write-first/new data).
REQ-005 SHALL have a single clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have port A inputs: en_a input 1, port enable; we_a input 1, write enable; be_a input DATA_WIDTH/8, byte write enables; addr_a input ADDR_WIDTH, address; din_a input DATA_WIDTH, write data.
REQ-007 SHALL have port A outputs: dout_a output DATA_WIDTH, read data; dvalid_a output 1, dout_a valid strobe.
REQ-008 SHALL have port B signals en_b, we_b, be_b, addr_b, din_b, dout_b and dvalid_b, identical in width and meaning to port A.
REQ-009 SHALL have init_start input 1, one-cycle request to clear the whole memory to zero.
REQ-010 SHALL have init_busy output 1, high while the clear sequence runs.
REQ-011 SHALL have coll_ww output 1, one-cycle pulse on a same-address write/write collision.
REQ-012 SHALL have coll_rw output 1, one-cycle pulse on a same-address read/write collision between ports.
REQ-013 SHALL have coll_cnt output 16, saturating count of all collisions.

Function
REQ-014 SHALL accept an operation on a port when en_x=1, init_busy=0 and rst_n=1; otherwise the port is idle.
REQ-015 SHALL, on an accepted write, update only the bytes whose be_x bit is 1; be_x=0 with we_x=1 SHALL be a no-op write that still returns read data.
REQ-016 SHALL, on an accepted read (we_x=0), present mem[addr_x] on dout_x exactly RD_LATENCY cycles later with dvalid_x=1 for one cycle.
REQ-017 SHALL, on an accepted write, also produce a dout_x/dvalid_x return after RD_LATENCY: the merged new word if WR_MODE=1, the prior word if WR_MODE=0.
REQ-018 SHALL hold dout_x at its last value when no return is due; dvalid_x=0 in those cycles.
REQ-019 SHALL fully pipeline both ports: one accepted operation per port per cycle, back-to-back, with no bubbles.
REQ-020 SHALL, when both ports write the same address in one cycle, make port A's enabled bytes win, apply port B's bytes not enabled in be_a, and pulse coll_ww.
REQ-021 SHALL, when one port writes and the other reads the same address in one cycle, return the new data to the reader if WR_MODE=1 and the old data if WR_MODE=0, and pulse coll_rw.
REQ-022 SHALL increment coll_cnt by 1 per collision cycle and hold it at 16'hFFFF once saturated.
REQ-023 SHALL implement an init FSM with states IDLE and CLEAR; init_start in IDLE SHALL move it to CLEAR, and init_start in CLEAR SHALL be ignored.
REQ-024 SHALL, in CLEAR, write zero to one address per cycle from 0 to depth-1, then return to IDLE; init_busy SHALL be high for exactly depth cycles.
REQ-025 SHALL ignore port requests while init_busy=1 (no writes, no dvalid), while still completing returns already in the read pipeline.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously clear dout_a, dout_b, dvalid_a, dvalid_b, coll_ww, coll_rw, coll_cnt and init_busy to 0, clear all pipeline stages, and force the FSM to IDLE.
REQ-027 SHALL leave memory contents unchanged on reset; a reset during CLEAR SHALL abort the sequence, leaving memory partially cleared.
REQ-028 SHALL drop in-flight read returns on reset, producing no dvalid after rst_n deasserts.

Verification
REQ-029 Bench SHALL cover: write A addr 5 = 32'hDEADBEEF, be=4'hF; read B addr 5 -> dout_b=32'hDEADBEEF with dvalid_b exactly RD_LATENCY cycles after the read (check both latencies).
REQ-030 Bench SHALL cover: addr 7 = 32'h11223344, then write A be=4'b0010 din=32'hFFFFAAFF -> read returns 32'h1122AA44.
REQ-031 Bench SHALL cover: same cycle A writes addr 9 = 32'hA, B writes addr 9 = 32'hB, full be -> mem[9]=32'hA, coll_ww pulses one cycle, coll_cnt=1.
REQ-032 Bench SHALL cover: addr 3 = 32'h1, then A writes addr 3 = 32'h2 while B reads addr 3 -> dout_b=32'h2 if WR_MODE=1 or 32'h1 if WR_MODE=0; coll_rw=1.
REQ-033 Bench SHALL cover: init_start pulse -> init_busy high for 2048 cycles, port requests ignored, all addresses read back 0 afterwards.
REQ-034 Bench SHALL cover: rst_n low at CLEAR cycle 100 -> outputs 0 immediately, FSM IDLE; addresses 0..99 read back 0 and address 100 onward retain prior data.
